// File: rtl/sample8.sv
// Registered 3-input lookup: F follows TRUTH_TABLE[{A,B,C}] one clock after
// the inputs are sampled. The only state in the block is the F register.
module sample8 #(
  parameter logic [7:0] TRUTH_TABLE = 8'hE8,
  parameter logic       RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic A,
  input  logic B,
  input  logic C,
  output logic F
);

  logic [2:0] w_idx;
  logic       w_f_next;
  logic       r_f;

  // A is the MSB of the index; X/Z on inputs deliberately propagates unresolved.
  assign w_idx    = {A, B, C};
  assign w_f_next = TRUTH_TABLE[w_idx];

  always_ff @(posedge clk) begin
    if (rst) r_f <= RESET_VALUE;
    else     r_f <= w_f_next;
  end

  assign F = r_f;

endmodule

// File: tb/tb_sample8.sv
// Bench for sample8: directed scenarios plus randomized traffic checked
// against arithmetic models of majority / XOR / constant tables.
module tb_sample8;

  logic clk = 1'b0;
  logic rst;
  logic A, B, C;
  logic f_maj, f_xor, f_zero, f_one;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sample8 dut_maj (.clk(clk), .rst(rst), .A(A), .B(B), .C(C), .F(f_maj));
  sample8 #(.TRUTH_TABLE(8'h96)) dut_xor (.clk(clk), .rst(rst), .A(A), .B(B), .C(C), .F(f_xor));
  sample8 #(.TRUTH_TABLE(8'h00)) dut_zero (.clk(clk), .rst(rst), .A(A), .B(B), .C(C), .F(f_zero));
  sample8 #(.TRUTH_TABLE(8'hFF), .RESET_VALUE(1'b1)) dut_one (.clk(clk), .rst(rst), .A(A), .B(B), .C(C), .F(f_one));

  // Reference: majority = at least two ones, XOR = odd count of ones.
  function automatic logic maj_ref(input logic [2:0] idx);
    return (int'(idx[2]) + int'(idx[1]) + int'(idx[0])) >= 2;
  endfunction

  function automatic logic xor_ref(input logic [2:0] idx);
    return ((int'(idx[2]) + int'(idx[1]) + int'(idx[0])) % 2) == 1;
  endfunction

  // Drive on the falling edge, then sample 1 time unit after the rising edge.
  task automatic apply(input logic [2:0] idx, input logic r);
    @(negedge clk);
    {A, B, C} = idx;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      apply(3'b111, 1'b1);
      checks++;
      if (f_maj !== 1'b0) begin failures++; $display("FAIL reset_maj cyc=%0d got=%b exp=0", k, f_maj); end
      checks++;
      if (f_one !== 1'b1) begin failures++; $display("FAIL reset_one cyc=%0d got=%b exp=1", k, f_one); end
    end
  endtask

  task automatic test_exhaustive();
    for (int i = 0; i < 8; i++) begin
      apply(3'(i), 1'b0);
      checks++;
      if (f_maj !== maj_ref(3'(i))) begin failures++; $display("FAIL exh_maj idx=%0d got=%b exp=%b", i, f_maj, maj_ref(3'(i))); end
      checks++;
      if (f_xor !== xor_ref(3'(i))) begin failures++; $display("FAIL exh_xor idx=%0d got=%b exp=%b", i, f_xor, xor_ref(3'(i))); end
      checks++;
      if (f_zero !== 1'b0 || f_one !== 1'b1) begin
        failures++; $display("FAIL exh_const idx=%0d got=%b%b exp=01", i, f_zero, f_one);
      end
    end
  endtask

  task automatic test_latency();
    apply(3'b000, 1'b0);
    checks++;
    if (f_maj !== 1'b0) begin failures++; $display("FAIL lat_first got=%b exp=0", f_maj); end
    @(negedge clk);
    {A, B, C} = 3'b011;
    #4;
    checks++;
    if (f_maj !== 1'b0) begin failures++; $display("FAIL lat_early got=%b exp=0", f_maj); end
    @(posedge clk);
    #1;
    checks++;
    if (f_maj !== 1'b1) begin failures++; $display("FAIL lat_second got=%b exp=1", f_maj); end
  endtask

  task automatic test_glitch();
    apply(3'b010, 1'b0);
    checks++;
    if (f_maj !== 1'b0) begin failures++; $display("FAIL glitch_pre got=%b exp=0", f_maj); end
    @(negedge clk);
    for (int t = 0; t < 4; t++) begin
      A = ~A;
      #1;
      checks++;
      if (f_maj !== 1'b0) begin failures++; $display("FAIL glitch_hold t=%0d got=%b exp=0", t, f_maj); end
    end
    {A, B, C} = 3'b110;
    @(posedge clk);
    #1;
    checks++;
    if (f_maj !== 1'b1) begin failures++; $display("FAIL glitch_edge got=%b exp=1", f_maj); end
  endtask

  task automatic test_midrun_reset();
    for (int i = 0; i < 7; i++) begin
      apply(3'(i), 1'b0);
      checks++;
      if (f_maj !== maj_ref(3'(i))) begin failures++; $display("FAIL mid_sweep idx=%0d got=%b exp=%b", i, f_maj, maj_ref(3'(i))); end
    end
    apply(3'b111, 1'b1);
    checks++;
    if (f_maj !== 1'b0) begin failures++; $display("FAIL mid_rst got=%b exp=0", f_maj); end
    apply(3'b101, 1'b0);
    checks++;
    if (f_maj !== 1'b1) begin failures++; $display("FAIL mid_resume got=%b exp=1", f_maj); end
  endtask

  task automatic test_random();
    logic [2:0] idx;
    logic       r;
    for (int n = 0; n < 300; n++) begin
      idx = 3'($urandom_range(0, 7));
      r   = ($urandom_range(0, 7) == 0);
      apply(idx, r);
      checks++;
      if (f_maj !== (r ? 1'b0 : maj_ref(idx)) || f_xor !== (r ? 1'b0 : xor_ref(idx)) ||
          f_zero !== 1'b0 || f_one !== 1'b1) begin
        failures++;
        $display("FAIL rand n=%0d idx=%0d rst=%b got=%b%b%b%b exp=%b%b01", n, idx, r,
                 f_maj, f_xor, f_zero, f_one, r ? 1'b0 : maj_ref(idx), r ? 1'b0 : xor_ref(idx));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    {A, B, C} = 3'b111;
    test_reset();
    test_exhaustive();
    test_latency();
    test_glitch();
    test_midrun_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sample8.md
SAMPLE8 -- requirements
Module: sample8

Interface
REQ-001 Parameter TRUTH_TABLE, default 8'hE8, SHALL hold the 8-bit function table; bit index {A,B,C} gives F. The default is 3-input majority.
REQ-002 Parameter RESET_VALUE, default 1'b0, SHALL be the value loaded into F on reset.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be the reset: synchronous and active-high.
REQ-005 Port A, input, 1 bit, SHALL be the function input and MSB of the table index.
REQ-006 Port B, input, 1 bit, SHALL be the function input and middle bit of the table index.
REQ-007 Port C, input, 1 bit, SHALL be the function input and LSB of the table index.
REQ-008 Port F, output, 1 bit, SHALL be the registered function result.

Function
REQ-009 Table index SHALL be idx = {A,B,C}, a 3-bit unsigned value, range 0..7.
REQ-010 Combinational next value SHALL be f_next = TRUTH_TABLE[idx].
REQ-011 On each rising clk edge with rst=0, F SHALL load f_next.
REQ-012 Latency SHALL be exactly one clock: F after edge k reflects A/B/C sampled at edge k.
REQ-013 F SHALL change only at rising clk edges; input changes between edges SHALL have no effect on F.
REQ-014 With the default table, F SHALL be 1 for idx 3, 5, 6 and 7, and 0 for idx 0, 1, 2 and 4.
REQ-015 The block SHALL need no handshake; inputs are sampled every cycle.
REQ-016 The block SHALL hold no state other than the F register.
REQ-017 Any X or Z on A, B or C SHALL NOT be resolved in RTL; behaviour is defined only for 0/1 inputs.
REQ-018 TRUTH_TABLE values 8'h00 and 8'hFF SHALL give constant F of 0 and 1 respectively, after reset.
REQ-019 Inputs changing on every cycle SHALL be tracked with no dropped samples.

Reset
REQ-020 When rst=1 at a rising clk edge, F SHALL load RESET_VALUE, whatever A, B and C are.
REQ-021 Reset SHALL take priority over function evaluation on the same edge.
REQ-022 Asserting rst mid-sequence SHALL force F to RESET_VALUE on the next edge; normal operation SHALL resume on the first edge with rst=0.
REQ-023 Before the first reset edge, F is undefined; verification SHALL NOT check F before reset.

Verification
REQ-024 Scenario "reset": rst=1 for 2 cycles with {A,B,C}=3'b111 -> F=0 after each edge (RESET_VALUE 0).
REQ-025 Scenario "exhaustive default": rst=0; apply idx 0..7, one per cycle -> F one cycle later = 0,0,0,1,0,1,1,1.
REQ-026 Scenario "latency": idx 3'b000 then 3'b011 at consecutive edges -> F=0 after the first edge and F=1 after the second, never earlier.
REQ-027 Scenario "glitch immunity": toggle A several times between edges, ending at 3'b110 before the edge -> F stays constant until the edge, then F=1.
REQ-028 Scenario "mid-run reset": during the exhaustive sweep, rst=1 at idx 3'b111 -> F=0 on that edge; rst=0 with idx 3'b101 -> F=1 on the next edge.
REQ-029 Scenario "alternate table": TRUTH_TABLE=8'h96 (3-input XOR), sweep idx 0..7 -> F = 0,1,1,0,1,0,0,1.
